b2g_sync_fifo: RTL and testbench
================================

// Module: b2g_sync_fifo
// PURPOSE
//   Parametrised single-clock FIFO; generalises the team's fixed 32-bit FIFO
//   DUT in width, depth, status thresholds and flush. Sits between producer
//   and consumer in one clock domain.
//   Primary DUT for the generated UVC env: write agent on wr_*, read agent on rd_*.
// PARAMETERS
//   DATA_WIDTH  32          payload width in bits, >=1
//   DEPTH       16          entries; power of two, >=2
//   AF_LEVEL    DEPTH-2     almost_full asserted when count >= AF_LEVEL
//   AE_LEVEL    2           almost_empty asserted when count <= AE_LEVEL
// PORTS
//   system_clock  in   1                 single clock, all logic on posedge
//   reset         in   1                 async, active-high; clears all state
//   flush         in   1                 sync clear of contents, same cycle
//   wr_en         in   1                 write request
//   wr_data       in   DATA_WIDTH        write payload
//   full          out  1                 count == DEPTH
//   almost_full   out  1                 count >= AF_LEVEL
//   rd_en         in   1                 read request
//   rd_data       out  DATA_WIDTH        registered read payload
//   rd_valid      out  1                 rd_data holds a popped word this cycle
//   empty         out  1                 count == 0
//   almost_empty  out  1                 count <= AE_LEVEL
//   count         out  $clog2(DEPTH+1)   current occupancy
// BEHAVIOUR
// - Reset: count=0, pointers=0, rd_data=0, rd_valid=0, empty=1, full=0,
//   almost_empty=1, almost_full=(AF_LEVEL==0); error flags cleared.
// - Accepted write: wr_en && !full (full sampled pre-edge); stores at wr_ptr,
//   wr_ptr++ mod DEPTH.
// - Accepted read: rd_en && !empty; rd_data <= mem[rd_ptr] next edge,
//   rd_valid=1 one cycle; rd_ptr++ mod DEPTH. Latency 1 cycle rd_en->rd_data.
// - No accepted read: rd_valid=0, rd_data holds last value.
// - Pointers log2(DEPTH) bits, natural wrap; count tracks occupancy
//   (no pointer-compare ambiguity).
// - Simultaneous accepted wr+rd: count unchanged; both pointers advance.
// - Write while full: rejected even if rd_en same cycle (no pass-through);
//   data dropped, count unchanged.
// - Read while empty: rejected even if wr_en same cycle; rd_valid=0.
// - All status flags are combinational decodes of registered count;
//   update the cycle after the causing edge.
// - flush: priority over wr/rd that cycle; next edge count=0, pointers=0,
//   rd_valid=0, rd_data held; the same-cycle write is discarded.
// - reset asserted mid-operation: immediate async clear as above; memory
//   contents not cleared (unreadable since empty=1).
// - Parameter check at elaboration: AF_LEVEL<=DEPTH, AE_LEVEL<DEPTH, DEPTH pow2.
// CONFIGURATION
//   B2G_FIFO_ERR_FLAGS_EN defined: adds ports
//     overflow   out 1  sticky; set on wr_en && full
//     underflow  out 1  sticky; set on rd_en && empty
//   both cleared only by reset or flush; set 1 cycle after offending request.
//   Undefined: ports absent, rejected requests silently ignored; data path
//   identical in both builds.
// TESTING
//   1. Reset then write 0x1..0x10 (DEPTH=16) -> full=1 after 16th edge,
//      count=16; almost_full rises when count reaches 14.
//   2. Read all 16 back -> rd_data 0x1..0x10 in order, each 1 cycle after
//      rd_en; empty=1 after last.
//   3. At count=8 drive wr_en&rd_en for 40 cycles -> count stays 8, order
//      preserved across pointer wrap.
//   4. Full + wr_en + rd_en -> read accepted, write dropped, count=15;
//      overflow=1 when B2G_FIFO_ERR_FLAGS_EN.
//   5. Empty + rd_en + wr_en(0xA5) -> rd_valid=0, count=1; next read
//      returns 0xA5; underflow=1 when macro defined.
//   6. count=5, assert flush with wr_en -> count=0, empty=1, write lost;
//      async reset pulse mid-burst -> all outputs reset values immediately.

Source files
------------

// File: rtl/b2g_sync_fifo.sv
// b2g_sync_fifo: parametrised single-clock FIFO with a registered read port.
// Define B2G_FIFO_ERR_FLAGS_EN to add sticky overflow/underflow outputs.
module b2g_sync_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 16,
    parameter int AF_LEVEL   = DEPTH - 2,
    parameter int AE_LEVEL   = 2
) (
    input  logic                         system_clock,
    input  logic                         reset,
    input  logic                         flush,
    input  logic                         wr_en,
    input  logic [DATA_WIDTH-1:0]        wr_data,
    output logic                         full,
    output logic                         almost_full,
    input  logic                         rd_en,
    output logic [DATA_WIDTH-1:0]        rd_data,
    output logic                         rd_valid,
    output logic                         empty,
    output logic                         almost_empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
`ifdef B2G_FIFO_ERR_FLAGS_EN
    ,
    output logic                         overflow,
    output logic                         underflow
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL_C = CW'(DEPTH);
    localparam logic [CW-1:0] AF_C   = CW'(AF_LEVEL);
    localparam logic [CW-1:0] AE_C   = CW'(AE_LEVEL);

    generate
        if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
            $error("b2g_sync_fifo: DEPTH must be a power of two >= 2");
        end
        if (AF_LEVEL > DEPTH || AF_LEVEL < 0) begin : g_bad_af
            $error("b2g_sync_fifo: AF_LEVEL must be <= DEPTH");
        end
        if (AE_LEVEL >= DEPTH || AE_LEVEL < 0) begin : g_bad_ae
            $error("b2g_sync_fifo: AE_LEVEL must be < DEPTH");
        end
        if (DATA_WIDTH < 1) begin : g_bad_dw
            $error("b2g_sync_fifo: DATA_WIDTH must be >= 1");
        end
    endgenerate

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
    logic                  rd_valid_q, rd_valid_d;
    logic                  wr_acc, rd_acc;

    // Flags decode the registered count only, so they lag the causing edge.
    assign full         = (count_q == FULL_C);
    assign empty        = (count_q == '0);
    assign almost_full  = (count_q >= AF_C);
    assign almost_empty = (count_q <= AE_C);
    assign count        = count_q;
    assign rd_data      = rd_data_q;
    assign rd_valid     = rd_valid_q;

    assign wr_acc = wr_en && !full && !flush;
    assign rd_acc = rd_en && !empty && !flush;

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (wr_acc) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (rd_acc) begin
                rd_ptr_d   = rd_ptr_q + AW'(1);
                rd_data_d  = mem_q[rd_ptr_q];
                rd_valid_d = 1'b1;
            end
            unique case ({wr_acc, rd_acc})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge system_clock or posedge reset) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    // Storage is deliberately not reset; empty=1 hides stale words.
    always_ff @(posedge system_clock) begin
        if (wr_acc) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

`ifdef B2G_FIFO_ERR_FLAGS_EN
    logic ovf_q, ovf_d;
    logic udf_q, udf_d;

    always_comb begin
        ovf_d = ovf_q | (wr_en && full);
        udf_d = udf_q | (rd_en && empty);
        if (flush) begin
            ovf_d = 1'b0;
            udf_d = 1'b0;
        end
    end

    always_ff @(posedge system_clock or posedge reset) begin
        if (reset) begin
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
            udf_q <= udf_d;
        end
    end

    assign overflow  = ovf_q;
    assign underflow = udf_q;
`endif

endmodule

// File: tb/tb_b2g_sync_fifo.sv
// tb_b2g_sync_fifo: directed scenarios plus random traffic for b2g_sync_fifo,
// checked against a queue-based model of the FIFO.
module tb_b2g_sync_fifo;

    localparam int DW    = 32;
    localparam int DEPTH = 16;
    localparam int AF    = DEPTH - 2;
    localparam int AE    = 2;
    localparam int CW    = $clog2(DEPTH + 1);

    logic          system_clock = 1'b0;
    logic          reset = 1'b1;
    logic          flush = 1'b0;
    logic          wr_en = 1'b0;
    logic [DW-1:0] wr_data = '0;
    logic          rd_en = 1'b0;
    logic          full, almost_full, empty, almost_empty, rd_valid;
    logic [DW-1:0] rd_data;
    logic [CW-1:0] count;
`ifdef B2G_FIFO_ERR_FLAGS_EN
    logic          overflow, underflow;
`endif

    b2g_sync_fifo #(
        .DATA_WIDTH(DW), .DEPTH(DEPTH), .AF_LEVEL(AF), .AE_LEVEL(AE)
    ) u_dut (
        .system_clock(system_clock),
        .reset(reset),
        .flush(flush),
        .wr_en(wr_en),
        .wr_data(wr_data),
        .full(full),
        .almost_full(almost_full),
        .rd_en(rd_en),
        .rd_data(rd_data),
        .rd_valid(rd_valid),
        .empty(empty),
        .almost_empty(almost_empty),
        .count(count)
`ifdef B2G_FIFO_ERR_FLAGS_EN
        ,
        .overflow(overflow),
        .underflow(underflow)
`endif
    );

    always #5 system_clock = ~system_clock;

    int n_chk = 0;
    int n_bad = 0;

    logic [DW-1:0] mq[$];
    logic [DW-1:0] m_rd = '0;
    logic          m_rdv = 1'b0;
    logic          m_ovf = 1'b0;
    logic          m_udf = 1'b0;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all(input string tag);
        int n;
        n = mq.size();
        chk({tag, ".count"}, 64'(count), 64'(n));
        chk({tag, ".empty"}, 64'(empty), 64'(n == 0));
        chk({tag, ".full"}, 64'(full), 64'(n == DEPTH));
        chk({tag, ".afull"}, 64'(almost_full), 64'(n >= AF));
        chk({tag, ".aempty"}, 64'(almost_empty), 64'(n <= AE));
        chk({tag, ".rdv"}, 64'(rd_valid), 64'(m_rdv));
        chk({tag, ".rdata"}, 64'(rd_data), 64'(m_rd));
`ifdef B2G_FIFO_ERR_FLAGS_EN
        chk({tag, ".ovf"}, 64'(overflow), 64'(m_ovf));
        chk({tag, ".udf"}, 64'(underflow), 64'(m_udf));
`endif
    endtask

    // One clock: drive, advance, update model, compare.
    task automatic step(input string tag, input logic w, input logic [DW-1:0] d,
                        input logic r, input logic f);
        logic wacc, racc, was_full, was_empty;
        wr_en = w; wr_data = d; rd_en = r; flush = f;
        was_full  = (mq.size() == DEPTH);
        was_empty = (mq.size() == 0);
        wacc = w && !was_full && !f;
        racc = r && !was_empty && !f;
        @(posedge system_clock);
        #1;
        if (f) begin
            mq.delete();
            m_rdv = 1'b0;
            m_ovf = 1'b0;
            m_udf = 1'b0;
        end else begin
            m_ovf = m_ovf | (w && was_full);
            m_udf = m_udf | (r && was_empty);
            m_rdv = racc;
            if (racc) m_rd = mq.pop_front();
            if (wacc) mq.push_back(d);
        end
        check_all(tag);
    endtask

    task automatic model_reset();
        mq.delete();
        m_rd = '0; m_rdv = 1'b0; m_ovf = 1'b0; m_udf = 1'b0;
    endtask

    initial begin
        repeat (3) @(posedge system_clock);
        #1;
        check_all("reset");
        reset = 1'b0;

        for (int i = 1; i <= DEPTH; i++) step("fill", 1, DW'(i), 0, 0);
        for (int i = 0; i < DEPTH; i++) step("drain", 0, '0, 1, 0);
        step("idle_rd", 0, '0, 0, 0);

        for (int i = 0; i < 8; i++) step("pre8", 1, $urandom, 0, 0);
        for (int i = 0; i < 40; i++) step("steady", 1, $urandom, 1, 0);

        while (mq.size() < DEPTH) step("tofull", 1, $urandom, 0, 0);
        step("full_wr_rd", 1, 32'hDEAD_BEEF, 1, 0);
        step("after_full", 0, '0, 0, 0);

        while (mq.size() > 0) step("toempty", 0, '0, 1, 0);
        step("empty_rd_wr", 1, 32'h0000_00A5, 1, 0);
        step("rd_a5", 0, '0, 1, 0);

        for (int i = 0; i < 5; i++) step("to5", 1, $urandom, 0, 0);
        step("flush_wr", 1, 32'h1234_5678, 0, 1);
        step("post_flush", 0, '0, 1, 0);

        for (int i = 0; i < 6; i++) step("burst", 1, $urandom, i[0], 0);
        reset = 1'b1;
        #1;
        model_reset();
        check_all("async_rst");
        reset = 1'b0;
        wr_en = 1'b0; rd_en = 1'b0;

        for (int i = 0; i < 400; i++) begin
            step("rand", ($urandom_range(0, 99) < 55), $urandom,
                 ($urandom_range(0, 99) < 45), ($urandom_range(0, 39) == 0));
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
